// File: rtl/weight_stream_source_if.sv
// weight_stream_source_if
//  AXI-Stream bundle for WEIGHT_CHANNELS lockstep weight channels.
//  All per-channel fields are packed with channel 0 in the LSBs.
//  master : drives tdata/tvalid/tlast/tid/tdest/tuser, receives tready
//  slave  : receives the payload, drives tready
interface weight_stream_source_if #(
  parameter int DATA_WIDTH_WEIGHT = 16,
  parameter int WEIGHT_CHANNELS   = 1,
  parameter int ID_WIDTH          = 8,
  parameter int DEST_WIDTH        = 8,
  parameter int USER_WIDTH        = 1
);
  logic [WEIGHT_CHANNELS*DATA_WIDTH_WEIGHT-1:0] tdata;
  logic [WEIGHT_CHANNELS-1:0]                   tvalid;
  logic [WEIGHT_CHANNELS-1:0]                   tready;
  logic [WEIGHT_CHANNELS-1:0]                   tlast;
  logic [WEIGHT_CHANNELS*ID_WIDTH-1:0]          tid;
  logic [WEIGHT_CHANNELS*DEST_WIDTH-1:0]        tdest;
  logic [WEIGHT_CHANNELS*USER_WIDTH-1:0]        tuser;

  modport master (
    output tdata, tvalid, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tlast, tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/weight_stream_source.sv
// weight_stream_source
//  Holds per-channel weight tables in on-chip RAM (one bank per channel) and
//  replays them once per start as WEIGHT_CHANNELS beat-aligned AXI-Stream
//  channels, with tlast marking the end of each row and of the replay.
// Ports
//  clk, rst       clock, synchronous active-high reset
//  wr_en/wr_addr  host write into all banks; wr_data packs channel 0 in LSBs
//  start          begin replay (only honoured while idle)
//  len, row_len   beats per replay (saturated at DEPTH), beats per tlast row
//                 (0 = tlast on final beat only); both latched on start
//  busy           replay in progress
//  done           one-cycle pulse when the final beat is accepted everywhere
//  m_axis_weight  AXI-Stream master bundle (tid/tdest/tuser constant)
module weight_stream_source #(
  parameter int DATA_WIDTH_WEIGHT = 16,
  parameter int WEIGHT_CHANNELS   = 1,
  parameter int DEPTH             = 256,
  parameter int ADDR_WIDTH        = $clog2(DEPTH),
  parameter int ID_WIDTH          = 8,
  parameter int DEST_WIDTH        = 8,
  parameter int USER_WIDTH        = 1,
  parameter int OUTPUT_ID         = 1,
  parameter int OUTPUT_DEST       = 0
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         wr_en,
  input  logic [ADDR_WIDTH-1:0]                        wr_addr,
  input  logic [WEIGHT_CHANNELS*DATA_WIDTH_WEIGHT-1:0] wr_data,
  input  logic                                         start,
  input  logic [ADDR_WIDTH:0]                          len,
  input  logic [ADDR_WIDTH:0]                          row_len,
  output logic                                         busy,
  output logic                                         done,
  weight_stream_source_if.master                       m_axis_weight
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH+1)'(1);

  logic [1:0]             state;
  logic [ADDR_WIDTH:0]    len_q;
  logic [ADDR_WIDTH:0]    row_len_q;
  logic [ADDR_WIDTH:0]    rd_idx;
  logic [ADDR_WIDTH:0]    row_cnt;
  logic [ADDR_WIDTH:0]    len_sat;
  logic                   rd_en;
  logic                   rd_last_beat;
  logic                   row_end;
  logic                   rd_tlast;
  logic                   done_r;
  logic                   drain_done;
  logic [WEIGHT_CHANNELS-1:0] ch_full;
  logic [WEIGHT_CHANNELS-1:0] ch_finishing;

  always_comb begin
    len_sat      = (len > DEPTH_L) ? DEPTH_L : len;
    // Reads advance only when every channel has a free slot, keeping all
    // channels beat-aligned even when their consumers stall independently.
    rd_en        = (state == ST_RUN) && ~|ch_full;
    rd_last_beat = (rd_idx == len_q - ONE);
    row_end      = (row_len_q != '0) && (row_cnt == row_len_q - ONE);
    rd_tlast     = row_end || rd_last_beat;
    drain_done   = !rst && (state == ST_DRAIN) && (&ch_finishing);
  end

  assign busy = (state != ST_IDLE);
  // Zero-length replays report through done_r; normal replays report in the
  // same cycle their final beat is accepted.
  assign done = done_r | drain_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      done_r    <= 1'b0;
      len_q     <= '0;
      row_len_q <= '0;
      rd_idx    <= '0;
      row_cnt   <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            len_q     <= len_sat;
            row_len_q <= row_len;
            rd_idx    <= '0;
            row_cnt   <= '0;
            if (len_sat == '0) begin
              done_r <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (rd_en) begin
            rd_idx  <= rd_idx + ONE;
            row_cnt <= row_end ? '0 : row_cnt + ONE;
            if (rd_last_beat) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar c = 0; c < WEIGHT_CHANNELS; c++) begin : g_ch
    logic [DATA_WIDTH_WEIGHT-1:0] mem [DEPTH];
    logic [DATA_WIDTH_WEIGHT-1:0] fifo_data [2];
    logic [1:0]                   fifo_last;
    logic                         wr_ptr;
    logic                         rd_ptr;
    logic [1:0]                   occ;
    logic                         pop;

    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem[wr_addr] <= wr_data[c*DATA_WIDTH_WEIGHT +: DATA_WIDTH_WEIGHT];
      end
    end

    // The synchronous bank read lands directly in the free FIFO slot, so the
    // FIFO entry doubles as the RAM output register: no separate in-flight
    // stage exists, and a same-cycle write to the read address yields the
    // old word.
    always_ff @(posedge clk) begin
      if (rd_en) begin
        fifo_data[wr_ptr] <= mem[rd_idx[ADDR_WIDTH-1:0]];
        fifo_last[wr_ptr] <= rd_tlast;
      end
    end

    assign pop = (occ != 2'd0) && m_axis_weight.tready[c];

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        occ    <= 2'd0;
      end else begin
        if (rd_en) wr_ptr <= ~wr_ptr;
        if (pop)   rd_ptr <= ~rd_ptr;
        case ({rd_en, pop})
          2'b10:   occ <= occ + 2'd1;
          2'b01:   occ <= occ - 2'd1;
          default: occ <= occ;
        endcase
      end
    end

    assign ch_full[c]      = (occ == 2'd2);
    assign ch_finishing[c] = (occ == 2'd0) || ((occ == 2'd1) && m_axis_weight.tready[c]);

    assign m_axis_weight.tvalid[c] = (occ != 2'd0);
    assign m_axis_weight.tdata[c*DATA_WIDTH_WEIGHT +: DATA_WIDTH_WEIGHT] = fifo_data[rd_ptr];
    assign m_axis_weight.tlast[c]  = (occ != 2'd0) && fifo_last[rd_ptr];
    assign m_axis_weight.tid[c*ID_WIDTH +: ID_WIDTH]       = ID_WIDTH'(OUTPUT_ID);
    assign m_axis_weight.tdest[c*DEST_WIDTH +: DEST_WIDTH] = DEST_WIDTH'(OUTPUT_DEST);
    assign m_axis_weight.tuser[c*USER_WIDTH +: USER_WIDTH] = '0;
  end

endmodule

// File: tb/tb_weight_stream_source.sv
module tb_weight_stream_source;

  localparam int DW    = 16;
  localparam int W     = 2;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W*DW-1:0] wr_data;
  logic          start;
  logic [AW:0]   len;
  logic [AW:0]   row_len;
  logic          busy;
  logic          done;

  weight_stream_source_if #(
    .DATA_WIDTH_WEIGHT(DW), .WEIGHT_CHANNELS(W),
    .ID_WIDTH(8), .DEST_WIDTH(8), .USER_WIDTH(1)
  ) axis ();

  weight_stream_source #(
    .DATA_WIDTH_WEIGHT(DW), .WEIGHT_CHANNELS(W), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
    .ID_WIDTH(8), .DEST_WIDTH(8), .USER_WIDTH(1), .OUTPUT_ID(1), .OUTPUT_DEST(0)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .len(len), .row_len(row_len), .busy(busy), .done(done),
    .m_axis_weight(axis)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  logic [DW-1:0] exp_mem0 [DEPTH];
  logic [DW-1:0] exp_mem1 [DEPTH];
  logic [DW:0]   q0 [$];
  logic [DW:0]   q1 [$];
  logic [W-1:0]  hold_v = '0;
  logic [DW+1:0] hold_d [W];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic write_word(input int a, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = {d1, d0};
    exp_mem0[a] = d0; exp_mem1[a] = d1;
    step();
    wr_en = 1'b0;
  endtask

  // Accepted beats, done pulses and AXI hold rules observed mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      hold_v = '0;
    end else begin
      if (done) done_cnt++;
      for (int c = 0; c < W; c++) begin
        if (hold_v[c])
          check("axis_hold", {axis.tvalid[c], axis.tdata[c*DW +: DW], axis.tlast[c]}, hold_d[c]);
        if (axis.tvalid[c] && axis.tready[c]) begin
          if (c == 0) q0.push_back({axis.tlast[0], axis.tdata[DW-1:0]});
          else        q1.push_back({axis.tlast[1], axis.tdata[2*DW-1:DW]});
        end
        hold_v[c] = axis.tvalid[c] && !axis.tready[c];
        hold_d[c] = {1'b1, axis.tdata[c*DW +: DW], axis.tlast[c]};
      end
    end
  end

  // mode 0: tready all high; 1: ch1 stalled 5 cycles; 2: random tready with a
  // second start issued while busy.
  task automatic run_stream(input string tag, input int n, input int rl, input int n_exp,
                            input logic [31:0] last_mask, input int mode);
    int d0;
    int cyc;
    d0  = done_cnt;
    cyc = 0;
    q0.delete(); q1.delete();
    axis.tready = 2'b11;
    start = 1'b1; len = (AW+1)'(n); row_len = (AW+1)'(rl);
    step();
    start = 1'b0;
    while (done_cnt == d0 && cyc < 400) begin
      case (mode)
        1:       axis.tready = (cyc >= 4 && cyc < 9) ? 2'b01 : 2'b11;
        2:       axis.tready = 2'($urandom_range(0, 3));
        default: axis.tready = 2'b11;
      endcase
      if (mode == 2 && cyc == 6) begin
        start = 1'b1; len = 5'd3; row_len = 5'd1;
      end
      #1;
      if (mode == 1 && cyc == 7) begin
        check({tag, "_stall_ch0_idle"}, axis.tvalid, 2'b10);
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    axis.tready = 2'b11;
    check({tag, "_done_seen"}, (cyc < 400), 1'b1);
    check({tag, "_count0"}, q0.size(), n_exp);
    check({tag, "_count1"}, q1.size(), n_exp);
    for (int i = 0; i < n_exp && i < q0.size() && i < q1.size(); i++) begin
      check({tag, "_ch0_beat"}, q0[i], {last_mask[i], exp_mem0[i]});
      check({tag, "_ch1_beat"}, q1[i], {last_mask[i], exp_mem1[i]});
    end
    step();
    check({tag, "_idle_after"}, {busy, axis.tvalid}, 3'b000);
  endtask

  initial begin
    int dc;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; len = '0; row_len = '0; axis.tready = 2'b11;
    step(); step(); step();
    check("rst_busy",   busy, 1'b0);
    check("rst_done",   done, 1'b0);
    check("rst_tvalid", axis.tvalid, 2'b00);
    check("rst_tlast",  axis.tlast, 2'b00);
    rst = 1'b0;
    check("tid",   axis.tid, 16'h0101);
    check("tdest", axis.tdest, 16'h0000);
    check("tuser", axis.tuser, 2'b00);

    for (int a = 0; a < DEPTH; a++) write_word(a, DW'(a), DW'(16'h0100 + a));

    // Test 1: exact latency, data and tlast timing.
    start = 1'b1; len = 5'd8; row_len = 5'd4;
    #1;
    check("t1_idle_busy", busy, 1'b0);
    step();
    start = 1'b0;
    check("t1_lat_tvalid", axis.tvalid, 2'b00);
    check("t1_busy", busy, 1'b1);
    for (int k = 0; k < 8; k++) begin
      step();
      check("t1_tvalid", axis.tvalid, 2'b11);
      check("t1_tdata", axis.tdata, {16'(16'h0100 + k), 16'(k)});
      check("t1_tlast", axis.tlast, (k == 3 || k == 7) ? 2'b11 : 2'b00);
      check("t1_done", done, (k == 7));
    end
    step();
    check("t1_end", {busy, done, axis.tvalid}, 4'b0000);

    // Test 2: independent backpressure on channel 1.
    run_stream("t2", 8, 4, 8, 32'h88, 1);

    // Test 3: zero-length replay.
    start = 1'b1; len = 5'd0; row_len = 5'd4;
    step();
    start = 1'b0;
    check("t3_done",   done, 1'b1);
    check("t3_busy",   busy, 1'b0);
    check("t3_tvalid", axis.tvalid, 2'b00);
    step();
    check("t3_done_off", {done, busy, axis.tvalid}, 4'b0000);

    // Test 4: row_len 0 and 2.
    run_stream("t4a", 5, 0, 5, 32'h10, 0);
    run_stream("t4b", 5, 2, 5, 32'h1A, 0);

    // Test 5: reset mid-replay, then a clean replay from word 0.
    dc = done_cnt;
    start = 1'b1; len = 5'd8; row_len = 5'd4;
    step(); start = 1'b0;
    step(); step(); step(); step();
    check("t5_beat3", axis.tdata[DW-1:0], 16'd3);
    rst = 1'b1;
    step();
    check("t5_tvalid", axis.tvalid, 2'b00);
    check("t5_busy",   busy, 1'b0);
    check("t5_done",   done, 1'b0);
    rst = 1'b0;
    step(); step(); step();
    check("t5_quiet", {busy, axis.tvalid}, 3'b000);
    check("t5_no_done", done_cnt, dc);
    run_stream("t5r", 8, 4, 8, 32'h88, 0);

    // Test 6: fresh contents, full depth, random backpressure, ignored start.
    for (int a = 0; a < DEPTH; a++)
      write_word(a, DW'(16'hA000 + a * 37), DW'(16'h5000 ^ (a * 113)));
    run_stream("t6", DEPTH, 5, DEPTH, 32'hC210, 2);
    // Oversized len saturates at DEPTH.
    run_stream("t6s", 20, 0, DEPTH, 32'h8000, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
